reg_writeback_queue: RTL

//  Producer side of the register-file write port (dest/writeVal/writeEn).

---
 rtl/reg_writeback_queue_pkg.sv | 6 +
 rtl/reg_writeback_queue_fwd_match.sv | 40 ++++
 rtl/reg_writeback_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// rtl/reg_writeback_queue_pkg.sv - shared register-file widths and writeback queue depth
package reg_writeback_queue_pkg;
  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int WB_QUEUE_DEPTH    = 4;
endpackage

// File: rtl/reg_writeback_queue_fwd_match.sv
// rtl/reg_writeback_queue_fwd_match.sv - youngest-pending-value lookup for one operand address
module wb_fwd_match #(
  parameter int WORD_LEN = reg_writeback_queue_pkg::WORD_LEN,
  parameter int ADDR_LEN = reg_writeback_queue_pkg::REG_FILE_ADDR_LEN,
  parameter int DEPTH    = reg_writeback_queue_pkg::WB_QUEUE_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic [ADDR_LEN-1:0] src_i,
  input  logic [ADDR_LEN-1:0] ent_dest_i [DEPTH],
  input  logic [WORD_LEN-1:0] ent_val_i  [DEPTH],
  input  logic [DEPTH-1:0]    ent_valid_i,
  input  logic [PTR_W-1:0]    head_i,
  input  logic                rf_en_i,
  input  logic [ADDR_LEN-1:0] rf_dest_i,
  input  logic [WORD_LEN-1:0] rf_val_i,
  output logic                hit_o,
  output logic [WORD_LEN-1:0] fwd_o
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to newest starting at the rf stage so later matches override earlier ones.
  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    idx   = head_i;
    if (src_i != '0) begin
      if (rf_en_i && rf_dest_i == src_i) begin
        hit_o = 1'b1;
        fwd_o = rf_val_i;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_i + PTR_W'(k);
        if (ent_valid_i[idx] && ent_dest_i[idx] == src_i) begin
          hit_o = 1'b1;
          fwd_o = ent_val_i[idx];
        end
      end
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order writeback FIFO feeding the register-file write port
module reg_writeback_queue #(
  parameter int WORD_LEN = reg_writeback_queue_pkg::WORD_LEN,
  parameter int ADDR_LEN = reg_writeback_queue_pkg::REG_FILE_ADDR_LEN,
  parameter int DEPTH    = reg_writeback_queue_pkg::WB_QUEUE_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_LEN-1:0] in_dest,
  input  logic [WORD_LEN-1:0] in_val,
  input  logic                hold,
  output logic [ADDR_LEN-1:0] rf_dest,
  output logic [WORD_LEN-1:0] rf_writeVal,
  output logic                rf_writeEn,
  input  logic [ADDR_LEN-1:0] src1,
  input  logic [ADDR_LEN-1:0] src2,
  output logic                hit1,
  output logic                hit2,
  output logic [WORD_LEN-1:0] fwd1,
  output logic [WORD_LEN-1:0] fwd2,
  output logic [PTR_W:0]      count,
  output logic                full,
  output logic                empty
);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_LEN-1:0] ent_dest_q [DEPTH];
  logic [WORD_LEN-1:0] ent_val_q  [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rf_en_q, rf_en_d;
  logic [ADDR_LEN-1:0] rf_dest_q, rf_dest_d;
  logic [WORD_LEN-1:0] rf_val_q, rf_val_d;
  logic [DEPTH-1:0]    valid_mask;
  logic [PTR_W-1:0]    rel;
  logic                push_hs, store, pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !rst;
  assign push_hs  = in_valid && in_ready;
  // Writes to r0 complete the handshake but are dropped here.
  assign store    = push_hs && (in_dest != '0);
  assign pop      = !empty && !hold;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rf_en_d   = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_val_d  = rf_val_q;
    if (pop) begin
      rf_en_d   = 1'b1;
      rf_dest_d = ent_dest_q[head_q];
      rf_val_d  = ent_val_q[head_q];
      head_d    = head_q + PTR_W'(1);
    end
    if (store) tail_d = tail_q + PTR_W'(1);
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_en_q   <= 1'b0;
      rf_dest_q <= '0;
      rf_val_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rf_en_q   <= rf_en_d;
      rf_dest_q <= rf_dest_d;
      rf_val_q  <= rf_val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      ent_dest_q[tail_q] <= in_dest;
      ent_val_q[tail_q]  <= in_val;
    end
  end

  // An entry is live when its distance from head is below the occupancy count.
  always_comb begin
    valid_mask = '0;
    rel        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel           = PTR_W'(i) - head_q;
      valid_mask[i] = ({1'b0, rel} < count_q);
    end
  end

  assign rf_writeEn  = rf_en_q;
  assign rf_dest     = rf_dest_q;
  assign rf_writeVal = rf_val_q;
  assign count       = count_q;

  wb_fwd_match #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH)) u_fwd1 (
    .src_i(src1), .ent_dest_i(ent_dest_q), .ent_val_i(ent_val_q), .ent_valid_i(valid_mask),
    .head_i(head_q), .rf_en_i(rf_en_q), .rf_dest_i(rf_dest_q), .rf_val_i(rf_val_q),
    .hit_o(hit1), .fwd_o(fwd1)
  );

  wb_fwd_match #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH)) u_fwd2 (
    .src_i(src2), .ent_dest_i(ent_dest_q), .ent_val_i(ent_val_q), .ent_valid_i(valid_mask),
    .head_i(head_q), .rf_en_i(rf_en_q), .rf_dest_i(rf_dest_q), .rf_val_i(rf_val_q),
    .hit_o(hit2), .fwd_o(fwd2)
  );
endmodule
